// File: rtl/spu_pkg.sv
// spu_pkg: shared types, command field positions, opcodes and helpers for the SPU sequencer
package spu_pkg;

    typedef enum logic {IDLE, RUN} state_t;

    localparam int OP_MSB  = 7;
    localparam int OP_LSB  = 4;
    localparam int CNT_MSB = 3;
    localparam int CNT_LSB = 0;

    localparam logic [3:0] OP_PASS = 4'd0;
    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_AND  = 4'd3;
    localparam logic [3:0] OP_OR   = 4'd4;
    localparam logic [3:0] OP_XOR  = 4'd5;
    localparam logic [3:0] OP_SHL  = 4'd6;
    localparam logic [3:0] OP_SHR  = 4'd7;

    // A zero count field encodes a full burst of 16 elements
    function automatic logic [4:0] cnt_decode(input logic [3:0] cnt);
        return (cnt == 4'd0) ? 5'd16 : {1'b0, cnt};
    endfunction

endpackage

// File: rtl/spu_res_fifo.sv
// spu_res_fifo: result buffer between the lane datapath and the dout ready/valid port
module spu_res_fifo #(
    parameter int DW         = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                wr_en,
    input  logic [DW-1:0]                       wr_data,
    input  logic                                rd_en,
    output logic [DW-1:0]                       rd_data,
    output logic                                empty,
    output logic                                full,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]     count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic [DW-1:0] mem_q [FIFO_DEPTH];
    logic [DW-1:0] mem_d [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          wr, rd;

    assign empty   = count_q == '0;
    assign full    = count_q == CW'(FIFO_DEPTH);
    assign count   = count_q;
    assign rd_data = mem_q[rd_ptr_q];
    assign rd      = rd_en && !empty;
    assign wr      = wr_en && (!full || rd);

    // Next pointers, occupancy and storage; power-of-two depth lets pointers wrap naturally
    always_comb begin
        mem_d = mem_q;
        if (wr) mem_d[wr_ptr_q] = wr_data;
        wr_ptr_d = wr_ptr_q + AW'(wr);
        rd_ptr_d = rd_ptr_q + AW'(rd);
        count_d  = count_q + CW'(wr) - CW'(rd);
    end

    // Register state; storage is cleared so the head reads 0 after reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/spu_seq_ctrl.sv
// spu_seq_ctrl: credit-gated command/operand sequencer for the Mini SPU lane.
// Optional macro SPU_OPCHK_EN adds opcode range checking with a sticky err output.
module spu_seq_ctrl #(
    parameter int DW         = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int NUM_OPS    = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [7:0]    cmd_data,
    input  logic          din_valid,
    output logic          din_ready,
    input  logic [DW-1:0] din_data,
    output logic          dp_issue,
    output logic [3:0]    dp_op,
    output logic [DW-1:0] dp_a,
    output logic          dp_last,
    input  logic          dp_res_valid,
    input  logic [DW-1:0] dp_res,
    output logic          dout_valid,
    input  logic          dout_ready,
    output logic [DW-1:0] dout_data,
    output logic          busy
`ifdef SPU_OPCHK_EN
    ,
    output logic          err
`endif
);

    import spu_pkg::*;

    localparam int CW = $clog2(FIFO_DEPTH + 1);

    state_t        state_q, state_d;
    logic [3:0]    op_q, op_d;
    logic [4:0]    rem_q, rem_d;
    logic          bad_q, bad_d;
    logic [CW-1:0] inflight_q, inflight_d;
    logic          skip_q;
    logic          dp_issue_q, dp_issue_d;
    logic [3:0]    dp_op_q, dp_op_d;
    logic [DW-1:0] dp_a_q, dp_a_d;
    logic          dp_last_q, dp_last_d;
    logic [CW-1:0] fifo_count;
    logic          fifo_empty;
    logic          cmd_hs, din_hs, res_ok, bad_cmd, has_credit;

`ifdef SPU_OPCHK_EN
    logic err_q, err_d;
    assign bad_cmd = {28'd0, cmd_data[OP_MSB:OP_LSB]} >= NUM_OPS;
    assign err     = err_q;
`else
    assign bad_cmd = 1'b0;
`endif

    // Credits count FIFO slots not yet claimed by buffered or in-flight results
    assign has_credit = ({1'b0, fifo_count} + {1'b0, inflight_q}) < (CW+1)'(FIFO_DEPTH);
    assign cmd_ready  = state_q == IDLE;
    assign din_ready  = state_q == RUN && (has_credit || bad_q);
    assign cmd_hs     = cmd_valid && cmd_ready;
    assign din_hs     = din_valid && din_ready;
    assign res_ok     = dp_res_valid && !skip_q;
    assign busy       = state_q != IDLE || inflight_q != '0 || !fifo_empty;
    assign dout_valid = !fifo_empty;
    assign dp_issue   = dp_issue_q;
    assign dp_op      = dp_op_q;
    assign dp_a       = dp_a_q;
    assign dp_last    = dp_last_q;

    // Command latch, element countdown, issue register and in-flight accounting
    always_comb begin
        state_d    = cmd_hs ? RUN : (din_hs && rem_q == 5'd1) ? IDLE : state_q;
        op_d       = cmd_hs ? cmd_data[OP_MSB:OP_LSB] : op_q;
        rem_d      = cmd_hs ? cnt_decode(cmd_data[CNT_MSB:CNT_LSB]) : din_hs ? rem_q - 5'd1 : rem_q;
        bad_d      = cmd_hs ? bad_cmd : bad_q;
        dp_issue_d = din_hs && !bad_q;
        dp_op_d    = dp_issue_d ? op_q : dp_op_q;
        dp_a_d     = dp_issue_d ? din_data : dp_a_q;
        dp_last_d  = dp_issue_d && rem_q == 5'd1;
        inflight_d = inflight_q + CW'(dp_issue_d) - CW'(res_ok && inflight_q != '0);
`ifdef SPU_OPCHK_EN
        err_d      = err_q || (cmd_hs && bad_cmd);
`endif
    end

    // Control state; skip_q masks a stale result strobe in the first cycle out of reset
    always_ff @(posedge clk) begin
        skip_q <= !rst_n;
        if (!rst_n) begin
            state_q    <= IDLE;
            op_q       <= '0;
            rem_q      <= '0;
            bad_q      <= 1'b0;
            inflight_q <= '0;
            dp_issue_q <= 1'b0;
            dp_op_q    <= '0;
            dp_a_q     <= '0;
            dp_last_q  <= 1'b0;
`ifdef SPU_OPCHK_EN
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            rem_q      <= rem_d;
            bad_q      <= bad_d;
            inflight_q <= inflight_d;
            dp_issue_q <= dp_issue_d;
            dp_op_q    <= dp_op_d;
            dp_a_q     <= dp_a_d;
            dp_last_q  <= dp_last_d;
`ifdef SPU_OPCHK_EN
            err_q      <= err_d;
`endif
        end
    end

    spu_res_fifo #(
        .DW         (DW),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (res_ok),
        .wr_data (dp_res),
        .rd_en   (dout_ready),
        .rd_data (dout_data),
        .empty   (fifo_empty),
        .full    (),
        .count   (fifo_count)
    );

endmodule
